// File: rtl/aes_selftest.sv
// aes_selftest: expands a fixed key, encrypts a fixed block, decrypts it back and lights one LED per key size.
// Define AES_KAT_CHECK_EN to also require the ciphertext to match the FIPS-197 known answer.
module aes_selftest (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] mod,
  output logic       led128,
  output logic       led192,
  output logic       led256
);
  // state  | meaning
  // IDLE   | wait for en with a valid mod; LEDs hold
  // LOAD   | copy the Nk key words into the schedule
  // KEYEXP | derive one schedule word per cycle
  // ENC    | initial AddRoundKey, then one cipher round per cycle
  // DEC    | inverse cipher, round keys walked downward
  // CHECK  | compare round trip, light the selected LED
  // DONE   | hold LEDs until en drops
  typedef enum logic [2:0] {IDLE, LOAD, KEYEXP, ENC, DEC, CHECK, DONE} state_t;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  state_t       state, state_nxt;
  logic [1:0]   mode;
  logic [3:0]   nk, nr;
  logic [5:0]   wlast;
  logic [31:0]  w [60];
  logic [5:0]   widx;
  logic [3:0]   kpos, rnd;
  logic [7:0]   rcon;
  logic         first;
  logic [31:0]  kprev, ktmp;
  logic [127:0] st, rk_cur, enc_nxt, dec_nxt, dec_sel;
  logic [127:0] in, en128out, en192out, en256out, dec128out, dec192out, dec256out;
  logic         start, busy, pass;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // byte i of a block is row i%4, column i/4
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o ^ rk;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] x, o;
    x = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = isbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    for (int i = 0; i < 16; i++) x[127-8*i -: 8] = t[i];
    x = x ^ rk;
    o = x;
    if (!last)
      for (int c = 0; c < 4; c++) begin
        a0 = x[127-32*c -: 8]; a1 = x[119-32*c -: 8]; a2 = x[111-32*c -: 8]; a3 = x[103-32*c -: 8];
        o[127-32*c -: 32] = {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                             gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                             gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                             gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
      end
    return o;
  endfunction

  always_comb begin
    nk = 4'd8; nr = 4'd14; wlast = 6'd59;
    case (mode)
      2'b00:   begin nk = 4'd4; nr = 4'd10; wlast = 6'd43; end
      2'b01:   begin nk = 4'd6; nr = 4'd12; wlast = 6'd51; end
      default: ;
    endcase
  end

  assign start  = (state == IDLE) && en && (mod != 2'b11);
  assign busy   = (state == LOAD) || (state == KEYEXP) || (state == ENC) ||
                  (state == DEC) || (state == CHECK);
  assign rk_cur = {w[{rnd, 2'b00}], w[{rnd, 2'b01}], w[{rnd, 2'b10}], w[{rnd, 2'b11}]};
  assign enc_nxt = enc_round(st, rk_cur, rnd == nr);
  assign dec_nxt = dec_round(st, rk_cur, rnd == 4'd0);

  always_comb begin
    kprev = w[widx - 6'd1];
    ktmp  = kprev;
    if (kpos == 4'd0) ktmp = subword({kprev[23:0], kprev[31:24]}) ^ {rcon, 24'h000000};
    else if (nk == 4'd8 && kpos == 4'd4) ktmp = subword(kprev);
  end

`ifdef AES_KAT_CHECK_EN
  logic [127:0] enc_sel, kat_sel;
`endif
  always_comb begin
    case (mode)
      2'b00:   dec_sel = dec128out;
      2'b01:   dec_sel = dec192out;
      default: dec_sel = dec256out;
    endcase
    pass = (dec_sel == in);
`ifdef AES_KAT_CHECK_EN
    case (mode)
      2'b00:   begin enc_sel = en128out; kat_sel = 128'h69c4e0d86a7b0430d8cdb78070b4c55a; end
      2'b01:   begin enc_sel = en192out; kat_sel = 128'hdda97ca4864cdfe06eaf70a0ec0d7191; end
      default: begin enc_sel = en256out; kat_sel = 128'h8ea2b7ca516745bfeafc49904b496089; end
    endcase
    pass = pass && (enc_sel == kat_sel);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = KEYEXP;
      KEYEXP:  if (widx == wlast) state_nxt = ENC;
      ENC:     if (!first && rnd == nr) state_nxt = DEC;
      DEC:     if (!first && rnd == 4'd0) state_nxt = CHECK;
      CHECK:   state_nxt = DONE;
      DONE:    if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (busy && !en) state_nxt = IDLE;
  end

  // datapath only advances while en holds; an abort leaves the LEDs cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode <= 2'b00; widx <= '0; kpos <= '0; rnd <= '0; rcon <= '0; first <= 1'b0;
      st <= '0; in <= '0;
      en128out <= '0; en192out <= '0; en256out <= '0;
      dec128out <= '0; dec192out <= '0; dec256out <= '0;
      led128 <= 1'b0; led192 <= 1'b0; led256 <= 1'b0;
      for (int i = 0; i < 60; i++) w[i] <= '0;
    end else if (en || !busy) begin
      case (state)
        IDLE: if (start) begin
          mode <= mod;
          in <= PT;
          led128 <= 1'b0; led192 <= 1'b0; led256 <= 1'b0;
        end
        LOAD: begin
          {w[0], w[1], w[2], w[3]} <= KEY[255:128];
          if (nk != 4'd4) {w[4], w[5]} <= KEY[127:64];
          if (nk == 4'd8) {w[6], w[7]} <= KEY[63:0];
          widx <= {2'b00, nk};
          kpos <= 4'd0;
          rcon <= 8'h01;
        end
        KEYEXP: begin
          w[widx] <= w[widx - {2'b00, nk}] ^ ktmp;
          widx <= widx + 6'd1;
          kpos <= (kpos == nk - 4'd1) ? 4'd0 : kpos + 4'd1;
          if (kpos == 4'd0) rcon <= xt(rcon);
          rnd <= 4'd0;
          first <= 1'b1;
        end
        ENC: if (first) begin
          st <= in ^ rk_cur;
          first <= 1'b0;
          rnd <= 4'd1;
        end else begin
          st <= enc_nxt;
          if (rnd == nr) begin
            first <= 1'b1;
            case (mode)
              2'b00:   en128out <= enc_nxt;
              2'b01:   en192out <= enc_nxt;
              default: en256out <= enc_nxt;
            endcase
          end else rnd <= rnd + 4'd1;
        end
        DEC: if (first) begin
          st <= st ^ rk_cur;
          first <= 1'b0;
          rnd <= rnd - 4'd1;
        end else begin
          st <= dec_nxt;
          if (rnd == 4'd0) begin
            case (mode)
              2'b00:   dec128out <= dec_nxt;
              2'b01:   dec192out <= dec_nxt;
              default: dec256out <= dec_nxt;
            endcase
          end else rnd <= rnd - 4'd1;
        end
        CHECK: if (pass) begin
          case (mode)
            2'b00:   led128 <= 1'b1;
            2'b01:   led192 <= 1'b1;
            default: led256 <= 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_selftest.sv
// tb_aes_selftest: randomized run/abort/reset/reserved-mode sequences checked against a
// latency-and-known-answer model of the self-test.
module tb_aes_selftest;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  logic       clk, reset, en;
  logic [1:0] mod;
  logic       led128, led192, led256;
  logic [2:0] leds;

  int           n_chk, n_pass;
  logic [2:0]   exp_leds;
  logic [127:0] exp_in;
  logic [127:0] exp_en  [3];
  logic [127:0] exp_dec [3];
  logic         exp_ok  [3];

  assign leds = {led256, led192, led128};

  aes_selftest dut (
    .clk(clk), .reset(reset), .en(en), .mod(mod),
    .led128(led128), .led192(led192), .led256(led256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] kat(input int m);
    case (m)
      0:       return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      1:       return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      default: return 128'h8ea2b7ca516745bfeafc49904b496089;
    endcase
  endfunction

  // start edge to LED edge: LOAD + KEYEXP + ENC + DEC + CHECK
  function automatic int latency(input int m);
    int nk, nr;
    nk = 4 + 2 * m;
    nr = 10 + 2 * m;
    return 1 + (4 * (nr + 1) - nk) + 2 * (nr + 1) + 1;
  endfunction

  function automatic logic [127:0] get_en(input int m);
    case (m)
      0:       return dut.en128out;
      1:       return dut.en192out;
      default: return dut.en256out;
    endcase
  endfunction

  function automatic logic [127:0] get_dec(input int m);
    case (m)
      0:       return dut.dec128out;
      1:       return dut.dec192out;
      default: return dut.dec256out;
    endcase
  endfunction

  task automatic chk_probes();
    chk("probe_in", dut.in, exp_in);
    for (int m = 0; m < 3; m++)
      if (exp_ok[m]) begin
        chk($sformatf("probe_ct%0d", m), get_en(m), exp_en[m]);
        chk($sformatf("probe_pt%0d", m), get_dec(m), exp_dec[m]);
      end
  endtask

  // called just after a rising edge; leaves the DUT in IDLE with en low
  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    exp_leds = '0;
    exp_in   = '0;
    for (int m = 0; m < 3; m++) begin
      exp_en[m] = '0; exp_dec[m] = '0; exp_ok[m] = 1'b1;
    end
    chk("rst_leds", 128'(leds), 128'(exp_leds));
    chk_probes();
    #2 reset = 1'b1;
    en = 1'b0;
    tick();
  endtask

  task automatic run_full(input int m);
    int lat;
    lat = latency(m);
    en = 1'b1;
    mod = m[1:0];
    tick();
    exp_leds = '0;
    exp_in = PT;
    chk("start_clr", 128'(leds), 128'(exp_leds));
    repeat (lat - 1) begin
      mod = 2'($urandom);
      tick();
    end
    chk($sformatf("led_early%0d", m), 128'(leds), 128'(exp_leds));
    tick();
    exp_leds = 3'(1 << m);
    chk($sformatf("led_rise%0d", m), 128'(leds), 128'(exp_leds));
    exp_en[m] = kat(m);
    exp_dec[m] = PT;
    exp_ok[m] = 1'b1;
    chk_probes();
    en = 1'b0;
    tick();
    tick();
    chk("led_hold", 128'(leds), 128'(exp_leds));
  endtask

  task automatic run_abort(input int m, input int c);
    int lat;
    lat = latency(m);
    en = 1'b1;
    mod = m[1:0];
    tick();
    exp_leds = '0;
    exp_in = PT;
    exp_ok[m] = 1'b0;
    chk("abort_start", 128'(leds), 128'(exp_leds));
    repeat (c) begin
      mod = 2'($urandom);
      tick();
    end
    en = 1'b0;
    repeat (lat) tick();
    chk($sformatf("abort_leds%0d_at%0d", m, c), 128'(leds), 128'(exp_leds));
  endtask

  task automatic run_reset(input int m, input int c);
    en = 1'b1;
    mod = m[1:0];
    tick();
    repeat (c) begin
      mod = 2'($urandom);
      tick();
    end
    pulse_reset();
  endtask

  task automatic run_mod11(input int n);
    logic [2:0] seen;
    seen = '0;
    en = 1'b1;
    mod = 2'b11;
    repeat (n) begin
      tick();
      seen = seen | leds;
    end
    chk("mod11_noled", 128'(seen), 128'(exp_leds));
    en = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, m, c;
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    en = 1'b0;
    mod = 2'b00;
    #1;
    pulse_reset();

    run_full(0);
    run_full(1);
    run_full(2);
    run_abort(2, 30);
    run_full(0);
    tick();
    pulse_reset();
    run_reset(2, 40);
    run_mod11(200);

    for (int it = 0; it < 14; it++) begin
      kind = int'($urandom_range(0, 4));
      m = int'($urandom_range(0, 2));
      c = int'($urandom_range(0, latency(m) - 1));
      case (kind)
        0, 1:    run_full(m);
        2:       run_abort(m, c);
        3:       run_reset(m, c);
        default: run_mod11(int'($urandom_range(5, 30)));
      endcase
    end
    run_full(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
